// File: rtl/control_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// State enum, ALU operation codes, opcode and funct constants.
package control_fsm_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLT  = 3'b010;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/control_decode.sv
// Combinational decode of the latched instruction into control fields.
// In: ir. Out: legal, alu_ctrl, alu_src, imm_src, is_branch.
// R-type support compiled in with `define CONTROL_RTYPE_EN.
module control_decode
  import control_fsm_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src,
  output logic        imm_src,
  output logic        is_branch
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7], funct7};

  always_comb begin
    legal     = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    imm_src   = 1'b0;
    is_branch = 1'b0;
    unique case (1'b1)
      (opcode == OP_IMM && funct3 == F3_ADDI): begin
        legal   = 1'b1;
        alu_src = 1'b1;
      end
      (opcode == OP_BRANCH && funct3 == F3_BNE): begin
        legal     = 1'b1;
        imm_src   = 1'b1;
        is_branch = 1'b1;
        alu_ctrl  = ALU_SUB;
      end
`ifdef CONTROL_RTYPE_EN
      (opcode == OP_REG): begin
        legal = 1'b1;
        unique case (1'b1)
          (funct3 == F3_ADD && funct7 == F7_ADD):
            alu_ctrl = ALU_ADD;
          (funct3 == F3_ADD && funct7 == F7_SUB):
            alu_ctrl = ALU_SUB;
          (funct3 == F3_AND):
            alu_ctrl = ALU_AND;
          (funct3 == F3_OR):
            alu_ctrl = ALU_OR;
          (funct3 == F3_SLT):
            alu_ctrl = ALU_SLT;
          default: begin
            legal    = 1'b0;
            alu_ctrl = ALU_ADD;
          end
        endcase
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Moore multicycle control FSM: FETCH, DECODE, EXEC, WB.
// In: clk, rst_n, instr, instr_valid, EQ. Out: instr_ready, ALUctrl,
// ALUsrc, ImmSrc, RegWrite, PCen, PCsrc, illegal. Macro: CONTROL_RTYPE_EN.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        EQ,
  output logic [2:0]  ALUctrl,
  output logic        ALUsrc,
  output logic        ImmSrc,
  output logic        RegWrite,
  output logic        PCen,
  output logic        PCsrc,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic       dec_legal;
  logic [2:0] dec_alu_ctrl;
  logic       dec_alu_src;
  logic       dec_imm_src;
  logic       dec_is_branch;

  control_decode u_decode (
    .ir        (ir_q),
    .legal     (dec_legal),
    .alu_ctrl  (dec_alu_ctrl),
    .alu_src   (dec_alu_src),
    .imm_src   (dec_imm_src),
    .is_branch (dec_is_branch)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE:
        state_d = dec_legal ? ST_EXEC : ST_FETCH;
      ST_EXEC:
        state_d = dec_is_branch ? ST_FETCH : ST_WB;
      ST_WB:
        state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs are masked while rst_n is low so a reset asserted
  // mid-instruction never leaks a write or PC update.
  always_comb begin
    instr_ready = 1'b0;
    ALUctrl     = ALU_ADD;
    ALUsrc      = 1'b0;
    ImmSrc      = 1'b0;
    RegWrite    = 1'b0;
    PCen        = 1'b0;
    PCsrc       = 1'b0;
    illegal     = 1'b0;
    if (!rst_n) begin
      instr_ready = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH:
          instr_ready = 1'b1;
        ST_DECODE: begin
          if (dec_legal) begin
            ImmSrc = dec_imm_src;
          end else begin
            illegal = 1'b1;
            PCen    = 1'b1;
          end
        end
        ST_EXEC: begin
          ALUctrl = dec_alu_ctrl;
          ALUsrc  = dec_alu_src;
          if (dec_is_branch) begin
            PCen  = 1'b1;
            PCsrc = ~EQ;
          end
        end
        ST_WB: begin
          RegWrite = 1'b1;
          PCen     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm.
// Covers reset, addi, bne, illegal, R-type word and back-to-back flow.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        EQ;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic        ImmSrc;
  logic        RegWrite;
  logic        PCen;
  logic        PCsrc;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W_ADDI = 32'h00500093;
  localparam logic [31:0] W_BNE  = 32'h00209463;
  localparam logic [31:0] W_BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] W_SUB  = 32'h402081B3;

  control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .EQ          (EQ),
    .ALUctrl     (ALUctrl),
    .ALUsrc      (ALUsrc),
    .ImmSrc      (ImmSrc),
    .RegWrite    (RegWrite),
    .PCen        (PCen),
    .PCsrc       (PCsrc),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] words [4];
  int k;
  int accepts;
  int pcen_cnt;
  int rw_cnt;
  int ill_cnt;

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    EQ          = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_pcen", 32'(PCen), 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_FETCH));

    // addi: FETCH, DECODE, EXEC, WB, then FETCH on cycle 5
    rst_n       = 1'b1;
    instr       = W_ADDI;
    instr_valid = 1'b1;
    chk("addi_c1_ready", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    chk("addi_dec_ready", 32'(instr_ready), 32'd0);
    chk("addi_dec_imm", 32'(ImmSrc), 32'd0);
    chk("addi_dec_pcen", 32'(PCen), 32'd0);
    step();
    chk("addi_ex_alu", 32'(ALUctrl), 32'(3'b000));
    chk("addi_ex_src", 32'(ALUsrc), 32'd1);
    chk("addi_ex_pcen", 32'(PCen), 32'd0);
    chk("addi_ex_rw", 32'(RegWrite), 32'd0);
    step();
    chk("addi_wb_rw", 32'(RegWrite), 32'd1);
    chk("addi_wb_pcen", 32'(PCen), 32'd1);
    chk("addi_wb_pcsrc", 32'(PCsrc), 32'd0);
    step();
    chk("addi_c5_ready", 32'(instr_ready), 32'd1);
    chk("addi_c5_rw", 32'(RegWrite), 32'd0);

    // reset held while in EXEC
    instr       = W_ADDI;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("mid_state_exec", 32'(dut.state_q), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_src", 32'(ALUsrc), 32'd0);
    step();
    rst_n = 1'b1;
    chk("mid_state", 32'(dut.state_q), 32'(ST_FETCH));
    chk("mid_ir", dut.ir_q, 32'd0);
    chk("mid_ready", 32'(instr_ready), 32'd1);
    chk("mid_rw", 32'(RegWrite), 32'd0);
    chk("mid_pcen", 32'(PCen), 32'd0);
    step();
    chk("mid_rw_next", 32'(RegWrite), 32'd0);
    chk("mid_pcen_next", 32'(PCen), 32'd0);

    // bne with EQ=0 then EQ=1
    for (int e = 0; e < 2; e++) begin
      EQ          = (e == 1);
      instr       = W_BNE;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("bne_dec_imm", 32'(ImmSrc), 32'd1);
      step();
      chk("bne_ex_alu", 32'(ALUctrl), 32'(3'b001));
      chk("bne_ex_src", 32'(ALUsrc), 32'd0);
      chk("bne_ex_pcen", 32'(PCen), 32'd1);
      chk("bne_ex_pcsrc", 32'(PCsrc), (e == 1) ? 32'd0 : 32'd1);
      chk("bne_ex_rw", 32'(RegWrite), 32'd0);
      step();
      chk("bne_back_ready", 32'(instr_ready), 32'd1);
      chk("bne_back_rw", 32'(RegWrite), 32'd0);
    end
    EQ = 1'b0;

    // illegal all-ones word
    instr       = W_BAD;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("bad_ill", 32'(illegal), 32'd1);
    chk("bad_pcen", 32'(PCen), 32'd1);
    chk("bad_rw", 32'(RegWrite), 32'd0);
    step();
    chk("bad_back_ready", 32'(instr_ready), 32'd1);
    chk("bad_back_ill", 32'(illegal), 32'd0);
    chk("bad_back_rw", 32'(RegWrite), 32'd0);

    // sub x3,x1,x2
    instr       = W_SUB;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
`ifdef CONTROL_RTYPE_EN
    chk("sub_dec_ill", 32'(illegal), 32'd0);
    step();
    chk("sub_ex_alu", 32'(ALUctrl), 32'(3'b001));
    chk("sub_ex_src", 32'(ALUsrc), 32'd0);
    step();
    chk("sub_wb_rw", 32'(RegWrite), 32'd1);
    step();
`else
    chk("sub_dec_ill", 32'(illegal), 32'd1);
    chk("sub_dec_pcen", 32'(PCen), 32'd1);
    step();
`endif
    chk("sub_back_ready", 32'(instr_ready), 32'd1);

    // back-to-back: addi(4) bne(3) addi(4) bne(3) = 14 cycles
    words[0] = W_ADDI;
    words[1] = W_BNE;
    words[2] = W_ADDI;
    words[3] = W_BNE;
    k        = 0;
    accepts  = 0;
    pcen_cnt = 0;
    rw_cnt   = 0;
    ill_cnt  = 0;
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (dut.state_q == ST_DECODE)
        chk("b2b_ir", dut.ir_q, words[k-1]);
      if (instr_ready && k < 4) begin
        instr = words[k];
        k++;
        accepts++;
      end else begin
        instr = W_BAD;
      end
      #1;
      pcen_cnt += int'(PCen);
      rw_cnt   += int'(RegWrite);
      ill_cnt  += int'(illegal);
      step();
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(accepts), 32'd4);
    chk("b2b_pcen", 32'(pcen_cnt), 32'd4);
    chk("b2b_rw", 32'(rw_cnt), 32'd2);
    chk("b2b_ill", 32'(ill_cnt), 32'd0);
    chk("b2b_end_ready", 32'(instr_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The module SHALL have clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have rst_n, input, 1 bit, a synchronous active-low reset.
REQ-003 The module SHALL have instr, input, 32 bits, the instruction word from instruction memory.
REQ-004 The module SHALL have instr_valid, input, 1 bit, meaning instr holds a valid instruction.
REQ-005 The module SHALL have instr_ready, output, 1 bit, meaning the FSM accepts an instruction this cycle.
REQ-006 The module SHALL have EQ, input, 1 bit, the ALU equality flag (ALUop1 == ALUop2).
REQ-007 The module SHALL have ALUctrl, output, 3 bits, the ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-008 The module SHALL have ALUsrc, output, 1 bit: 1 selects the immediate as ALUop2, 0 selects the register.
REQ-009 The module SHALL have ImmSrc, output, 1 bit: 0 selects the I-type immediate, 1 selects the B-type immediate.
REQ-010 The module SHALL have RegWrite, PCen and PCsrc, outputs, 1 bit each: register-file write enable, PC update enable, and branch-target select.
REQ-011 The module SHALL have illegal, output, 1 bit, a one-cycle pulse flagging an unsupported instruction.

Function
REQ-012 The module SHALL implement the Moore states FETCH, DECODE, EXEC and WB, with all outputs decoded from the state and the latched instruction only.
- FETCH: instr_ready=1; on instr_valid=1, latch instr into ir and go to DECODE; otherwise stay in FETCH.
- DECODE: decode ir.
  - addi (opcode 0010011, funct3 000): ImmSrc=0, go to EXEC.
  - bne (opcode 1100011, funct3 001): ImmSrc=1, go to EXEC.
  - Anything else: illegal=1 and PCen=1 (PC+4) this cycle, go to FETCH.
- EXEC, addi: ALUctrl=000, ALUsrc=1, go to WB.
- EXEC, bne: ALUctrl=001, ALUsrc=0, PCen=1, PCsrc=~EQ sampled this cycle, go to FETCH.
- WB: RegWrite=1, PCen=1, PCsrc=0, go to FETCH.
REQ-013 In every state where an output is not listed above, that output SHALL be 0, and ALUctrl SHALL be 000.
REQ-014 Latency SHALL be 4 cycles per ALU instruction (FETCH to WB), 3 per branch and 2 per illegal instruction, assuming instr_valid is already high.
REQ-015 PCen SHALL be high exactly one cycle per accepted instruction; RegWrite SHALL never be high for a branch or an illegal instruction.
REQ-016 ir SHALL only load in FETCH while instr_valid=1; instr changes at any other time SHALL be ignored.
REQ-017 A back-to-back instr_valid SHALL be accepted on the first FETCH cycle after returning from WB, EXEC or DECODE.

Reset
REQ-018 When rst_n=0 at a clock edge, the state SHALL become FETCH and ir SHALL become 0, from any state including mid-instruction; no partial write or PC update SHALL follow.
REQ-019 During and immediately after reset, all outputs SHALL be 0 except instr_ready=1.

Configuration
REQ-020 The macro CONTROL_RTYPE_EN SHALL compile R-type support in or out.
- Defined: opcode 0110011 is legal in DECODE. In EXEC, ALUsrc=0 and ALUctrl is decoded as:
  - add (funct3 000, funct7 0000000): 000
  - sub (funct3 000, funct7 0100000): 001
  - and (funct3 111): 010
  - or (funct3 110): 011
  - slt (funct3 010): 101
  - The state then goes to WB. Any other funct combination raises illegal.
- Undefined: opcode 0110011 is treated as illegal.

Structure
REQ-021 A shared package SHALL hold the state enum, the ALUctrl encodings as named constants, and the opcode/funct3 constants.
REQ-022 One sub-module, control_decode, SHALL be used: combinational ir-to-control decode. It holds the legal flag, ALUctrl, ALUsrc, ImmSrc and is_branch; the FSM stays in control_fsm.

Verification
REQ-023 Reset: hold rst_n=0 in EXEC, then release it.
- Required: state is FETCH and instr_ready=1.
- Required: RegWrite=0 and PCen=0 for the whole next cycle.
REQ-024 addi x1,x0,5 (0x00500093) presented with instr_valid=1.
- Required: EXEC shows ALUctrl=000 and ALUsrc=1.
- Required: WB shows RegWrite=1 and PCen=1 on cycle 4; instr_ready is high again on cycle 5.
REQ-025 bne (0x00209463) with EQ=0.
- Required: EXEC cycle has PCen=1 and PCsrc=1.
- Repeat with EQ=1. Required: PCsrc=0. RegWrite stays 0 in both cases.
REQ-026 Word 0xFFFFFFFF.
- Required: illegal=1 and PCen=1 in DECODE; back in FETCH the next cycle; RegWrite never asserts.
REQ-027 With CONTROL_RTYPE_EN defined, sub x3,x1,x2 (0x402081B3).
- Required: ALUctrl=001 and ALUsrc=0 in EXEC, then RegWrite=1.
- Without the macro, the same word SHALL raise illegal.
REQ-028 instr_valid held high continuously with alternating addi and bne words.
- Required: each word is accepted exactly once and PCen pulses once per instruction.
- Required: a word changed during DECODE is not captured.
